// File: rtl/dtree_vote_accum.sv
// dtree_vote_accum: majority-vote stage behind the decision-tree classifier.
// It takes one 4-bit class label per handshake and builds a per-class
// histogram over WINDOW samples. It then scans the histogram one class per
// cycle and presents the most frequent class and its count.
// Optional feature macro: DTREE_VOTE_INVCNT_EN adds the inv_count port and an
// out-of-range label counter.
module dtree_vote_accum #(
  parameter int NUM_CLASSES = 10,
  parameter int WINDOW      = 8,
  parameter int CNT_W       = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_class,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_class,
  output logic [CNT_W-1:0] out_count
`ifdef DTREE_VOTE_INVCNT_EN
  ,
  output logic [CNT_W-1:0] inv_count
`endif
);

  localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_CLASSES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(WINDOW - 1);
  localparam logic [4:0]       NC5         = 5'(NUM_CLASSES);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] hist_q [NUM_CLASSES];
  logic [CNT_W-1:0] sample_cnt_q;
  logic [IDX_W-1:0] scan_idx_q;
  logic [3:0]       best_class_q;
  logic [CNT_W-1:0] best_count_q;
  logic             out_valid_q;
  logic [3:0]       out_class_q;
  logic [CNT_W-1:0] out_count_q;

  logic in_ready_c;
  logic acc_take;
  logic label_ok;
  logic last_take;
  logic scan_last;
  logic out_hs;
  logic win_clr;

  // A label is taken only in ACCUM. A simultaneous clear drops it.
  assign label_ok  = ({1'b0, in_class} < NC5);
  assign acc_take  = (state_q == ACCUM) && in_valid && !clear;
  assign last_take = acc_take && (sample_cnt_q == SAMPLE_LAST);
  assign scan_last = (state_q == SCAN) && (scan_idx_q == IDX_LAST);
  // out_valid is registered, so the handshake uses the registered flag.
  assign out_hs    = (state_q == OUT) && out_valid_q && out_ready;
  // The window state is zeroed on abort in ACCUM and after a delivered result.
  assign win_clr   = ((state_q == ACCUM) && clear) || out_hs;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (last_take) state_d = SCAN;
      SCAN:    if (scan_last) state_d = OUT;
      OUT:     if (out_hs)    state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // FSM outputs: in_ready depends on state only
  always_comb begin
    in_ready_c = 1'b0;
    if (state_q == ACCUM) in_ready_c = 1'b1;
  end

  assign in_ready = in_ready_c;

  // One saturation-free counter per class. Its maximum value is WINDOW, which fits CNT_W.
  generate
    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_hist
      // Count accepted in-range labels that match this bin
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hist_q[gi] <= '0;
        end else if (win_clr) begin
          hist_q[gi] <= '0;
        end else if (acc_take && label_ok && (in_class == 4'(gi))) begin
          hist_q[gi] <= hist_q[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  // Sample counter: every accepted label uses a window slot, valid or not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt_q <= '0;
    end else if (win_clr || last_take) begin
      sample_cnt_q <= '0;
    end else if (acc_take) begin
      sample_cnt_q <= sample_cnt_q + CNT_W'(1);
    end
  end

  // Scan index walks 0..NUM_CLASSES-1 while in SCAN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_idx_q <= '0;
    end else if ((state_q == SCAN) && !scan_last) begin
      scan_idx_q <= scan_idx_q + IDX_W'(1);
    end else begin
      scan_idx_q <= '0;
    end
  end

  // Running maximum. A strict compare means ties keep the lowest class index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_class_q <= '0;
      best_count_q <= '0;
    end else if (out_hs) begin
      best_class_q <= '0;
      best_count_q <= '0;
    end else if ((state_q == SCAN) && (hist_q[scan_idx_q] > best_count_q)) begin
      best_class_q <= 4'(scan_idx_q);
      best_count_q <= hist_q[scan_idx_q];
    end
  end

  // Result registers load on the first OUT cycle and then hold until the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_count_q <= '0;
    end else begin
      out_valid_q <= (state_q == OUT) && !out_hs;
      if ((state_q == OUT) && !out_valid_q) begin
        out_class_q <= best_class_q;
        out_count_q <= best_count_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_count = out_count_q;

`ifdef DTREE_VOTE_INVCNT_EN
  logic [CNT_W-1:0] inv_cnt_q;

  // Count out-of-range labels. The count is cleared together with the histogram.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_cnt_q <= '0;
    end else if (win_clr) begin
      inv_cnt_q <= '0;
    end else if (acc_take && !label_ok) begin
      inv_cnt_q <= inv_cnt_q + CNT_W'(1);
    end
  end

  assign inv_count = inv_cnt_q;
`endif

endmodule

// File: tb/tb_dtree_vote_accum.sv
// Directed testbench for dtree_vote_accum with NUM_CLASSES=10 and WINDOW=8.
// It checks against hand-computed expected values.
module tb_dtree_vote_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_class;
  logic       clear;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_class;
  logic [3:0] out_count;
`ifdef DTREE_VOTE_INVCNT_EN
  logic [3:0] inv_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dtree_vote_accum #(
    .NUM_CLASSES(10),
    .WINDOW     (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_class (in_class),
    .clear    (clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_class(out_class),
    .out_count(out_count)
`ifdef DTREE_VOTE_INVCNT_EN
    ,
    .inv_count(inv_count)
`endif
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, got);
    end
  endtask

  // Present one label for one cycle. The block is in ACCUM, so it is taken at this edge.
  task automatic push(input logic [3:0] c);
    in_valid = 1'b1;
    in_class = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Send eight labels back to back. The leftmost hex digit is sent first.
  task automatic send_window(input logic [31:0] labels);
    for (int i = 0; i < 8; i++) push(labels[31-4*i -: 4]);
  endtask

  // Wait for out_valid, bounded, and check the latency after the last accept.
  task automatic wait_result(input string tag);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 3) check_eq({tag, "_scan_ready"}, int'(in_ready), 0);
    end
    check_eq({tag, "_latency"}, n, 11);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, "_hs_ready"}, int'(in_ready), 1);
    check_eq({tag, "_hs_valid"}, int'(out_valid), 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_class  = 4'd0;
    clear     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", int'(in_ready), 1);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_out_class", int'(out_class), 0);
    check_eq("rst_out_count", int'(out_count), 0);
`ifdef DTREE_VOTE_INVCNT_EN
    check_eq("rst_inv_count", int'(inv_count), 0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic vote: 3,3,3,5,5,1,3,7 gives class 3 with count 4
    send_window(32'h3335_5137);
    wait_result("basic");
    check_eq("basic_class", int'(out_class), 3);
    check_eq("basic_count", int'(out_count), 4);
    handshake("basic");

    // Tie between 6, 2 and 9: the lowest index (2) wins. Also hold backpressure for 5 cycles.
    send_window(32'h6622_9941);
    wait_result("tie");
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("bp%0d_valid", k), int'(out_valid), 1);
      check_eq($sformatf("bp%0d_class", k), int'(out_class), 2);
      check_eq($sformatf("bp%0d_count", k), int'(out_count), 2);
      check_eq($sformatf("bp%0d_ready", k), int'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    handshake("tie");

    // Every label is out of range, so the result is class 0 with count 0
    send_window(32'hEEEE_EEEE);
    wait_result("allinv");
    check_eq("allinv_class", int'(out_class), 0);
    check_eq("allinv_count", int'(out_count), 0);
`ifdef DTREE_VOTE_INVCNT_EN
    check_eq("allinv_inv", int'(inv_count), 8);
`endif
    handshake("allinv");

    // Mixed window: 12,15,4,4,4,0,0,11 gives class 4 with count 3
    send_window(32'hCF44_400B);
    wait_result("inv");
    check_eq("inv_class", int'(out_class), 4);
    check_eq("inv_count", int'(out_count), 3);
`ifdef DTREE_VOTE_INVCNT_EN
    check_eq("inv_invcnt", int'(inv_count), 3);
`endif
    handshake("inv");

    // Assert reset after five samples of label 7
    for (int i = 0; i < 5; i++) push(4'd7);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mrst_in_ready", int'(in_ready), 1);
    check_eq("mrst_out_valid", int'(out_valid), 0);
    check_eq("mrst_out_class", int'(out_class), 0);
    check_eq("mrst_out_count", int'(out_count), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_window(32'h1111_1111);
    wait_result("mrst");
    check_eq("mrst_class", int'(out_class), 1);
    check_eq("mrst_count", int'(out_count), 8);
    handshake("mrst");

    // Clear aborts the window. The label sent in the same cycle as clear is dropped.
    for (int i = 0; i < 4; i++) push(4'd5);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_class = 4'd5;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    send_window(32'h8888_8888);
    wait_result("clr");
    check_eq("clr_class", int'(out_class), 8);
    check_eq("clr_count", int'(out_count), 8);
    handshake("clr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
